// File: rtl/div_unit.sv
// div_unit: multi-cycle 32/32 radix-2 restoring divider for the EX stage.
// Returns {remainder, quotient} for HI/LO once ready_o rises; the EX stage
// holds start_i high until it has consumed the result.
// Optional build macro: DIV_EARLY_EXIT_EN (skip the iterations when the
// dividend magnitude is smaller than the divisor magnitude).
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W:0]   partial;
  logic [DATA_W-1:0]   divisor_mag;
  logic                neg_quot;
  logic                neg_rem;

  logic                op1_neg;
  logic                op2_neg;
  logic [DATA_W-1:0]   op1_mag;
  logic [DATA_W-1:0]   op2_mag;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Operand magnitudes, the trial subtraction and the final sign correction.
  // The partial register keeps the running remainder in [2W:W+1] and the
  // quotient bits shifting in from bit 0; the dividend enters at bit 1 so
  // that after exactly DATA_W iterations the remainder lands in [2W:W+1].
  always_comb begin
    op1_neg  = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg  = signed_div_i & opdata2_i[DATA_W-1];
    op1_mag  = op1_neg ? ({DATA_W{1'b0}} - opdata1_i) : opdata1_i;
    op2_mag  = op2_neg ? ({DATA_W{1'b0}} - opdata2_i) : opdata2_i;
    trial    = {1'b0, partial[2*DATA_W-1:DATA_W]} - {1'b0, divisor_mag};
    quot     = partial[DATA_W-1:0];
    rem      = partial[2*DATA_W:DATA_W+1];
    quot_fix = neg_quot ? ({DATA_W{1'b0}} - quot) : quot;
    rem_fix  = neg_rem  ? ({DATA_W{1'b0}} - rem)  : rem;
  end

  // Divide FSM: accept, iterate one quotient bit per clock, hold the result
  // until EX drops start_i; annul or a dropped start abandons the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DIV_FREE;
      cnt         <= '0;
      partial     <= '0;
      divisor_mag <= '0;
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
      ready_o     <= 1'b0;
      result_o    <= '0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            divisor_mag <= op2_mag;
            neg_quot    <= op1_neg ^ op2_neg;
            neg_rem     <= op1_neg;
            cnt         <= '0;
            partial     <= {{DATA_W{1'b0}}, op1_mag, 1'b0};
            if (opdata2_i == '0) begin
              state <= DIV_BY_ZERO;
`ifdef DIV_EARLY_EXIT_EN
            end else if (op1_mag < op2_mag) begin
              state    <= DIV_END;
              result_o <= {opdata1_i, {DATA_W{1'b0}}};
`endif
            end else begin
              state <= DIV_ON;
            end
          end
        end
        DIV_BY_ZERO: begin
          if (annul_i || !start_i) begin
            state <= DIV_FREE;
          end else begin
            state    <= DIV_END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        DIV_ON: begin
          if (annul_i || !start_i) begin
            state <= DIV_FREE;
            cnt   <= '0;
          end else if (cnt != LAST_CNT) begin
            if (trial[DATA_W]) begin
              partial <= {partial[2*DATA_W-1:0], 1'b0};
            end else begin
              partial <= {trial[DATA_W-1:0], partial[DATA_W-1:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end else begin
            result_o <= {rem_fix, quot_fix};
            ready_o  <= 1'b1;
            state    <= DIV_END;
            cnt      <= '0;
          end
        end
        DIV_END: begin
          if (!start_i) begin
            state    <= DIV_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            ready_o <= 1'b1;
          end
        end
        default: begin
          state <= DIV_FREE;
        end
      endcase
    end
  end

endmodule
